// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and sync-level helper for the VGA timing block.
package vga_timing_pkg;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int SYNC_ACTIVE_LOW_DEF = 1;

  // Pin level for a sync signal given whether its window is currently active.
  function automatic logic sync_level(input logic active_low, input logic active);
    return active_low ? ~active : active;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus visible and sync window decode.
module vga_axis_counter #(
  parameter int WIDTH   = 11,
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap,
  output logic             o_visible,
  output logic             o_sync
);
  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [WIDTH-1:0] LAST     = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] VIS_END  = WIDTH'(VISIBLE);
  localparam logic [WIDTH-1:0] SYNC_BEG = WIDTH'(VISIBLE + FRONT);
  localparam logic [WIDTH-1:0] SYNC_END = WIDTH'(VISIBLE + FRONT + SYNC);

  assign o_wrap    = i_en && (o_count == LAST);
  assign o_visible = o_count < VIS_END;
  assign o_sync    = (o_count >= SYNC_BEG) && (o_count < SYNC_END);

  // Clear wins over counting so a soft reset parks the raster at the origin.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   o_count <= '0;
    else if (i_clear) o_count <= '0;
    else if (i_en)    o_count <= o_wrap ? '0 : o_count + 1'b1;
  end
endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing with one registered stage aligning RGB and sync at the pins.
// Optional colour-bar source enabled by defining VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int PIXEL_BITWIDTH  = 11,
  parameter int RGB_BITWIDTH    = 8,
  parameter int H_VISIBLE       = H_VISIBLE_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_VISIBLE       = V_VISIBLE_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter int SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_vga_reset_n,
  output logic [PIXEL_BITWIDTH-1:0] o_vga_x,
  output logic [PIXEL_BITWIDTH-1:0] o_vga_y,
  input  logic [RGB_BITWIDTH-1:0]   i_red,
  input  logic [RGB_BITWIDTH-1:0]   i_green,
  input  logic [RGB_BITWIDTH-1:0]   i_blue,
`ifdef VGA_TIMING_TEST_PATTERN_EN
  input  logic                      i_test_pattern,
`endif
  output logic [RGB_BITWIDTH-1:0]   o_vga_red,
  output logic [RGB_BITWIDTH-1:0]   o_vga_green,
  output logic [RGB_BITWIDTH-1:0]   o_vga_blue,
  output logic                      o_vga_hsync,
  output logic                      o_vga_vsync,
  output logic                      o_visible,
  output logic                      o_frame_start
);
  localparam logic ACT_LOW  = (SYNC_ACTIVE_LOW != 0);
  localparam logic SYNC_OFF = ACT_LOW;

  logic h_wrap, h_vis, h_sync;
  logic v_wrap, v_vis, v_sync;
  logic clear, at_origin, vis;
  logic [RGB_BITWIDTH-1:0] src_r, src_g, src_b;

  assign clear = !i_vga_reset_n;
  assign vis   = h_vis && v_vis;

  vga_axis_counter #(
    .WIDTH(PIXEL_BITWIDTH), .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clear(clear), .i_en(1'b1),
    .o_count(o_vga_x), .o_wrap(h_wrap), .o_visible(h_vis), .o_sync(h_sync)
  );

  vga_axis_counter #(
    .WIDTH(PIXEL_BITWIDTH), .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clear(clear), .i_en(h_wrap),
    .o_count(o_vga_y), .o_wrap(v_wrap), .o_visible(v_vis), .o_sync(v_sync)
  );

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = H_VISIBLE / 8;
  logic [2:0] bar;
  assign bar = 3'(o_vga_x / PIXEL_BITWIDTH'(BAR_W));

  always_comb begin
    src_r = i_red;
    src_g = i_green;
    src_b = i_blue;
    if (i_test_pattern) begin
      src_r = {RGB_BITWIDTH{bar[0]}};
      src_g = {RGB_BITWIDTH{bar[1]}};
      src_b = {RGB_BITWIDTH{bar[2]}};
    end
  end
`else
  assign src_r = i_red;
  assign src_g = i_green;
  assign src_b = i_blue;
`endif

  // High while the counters present (0,0): after any reset or a frame wrap.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)          at_origin <= 1'b1;
    else if (!i_vga_reset_n) at_origin <= 1'b1;
    else                     at_origin <= v_wrap;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n || !i_vga_reset_n) begin
      o_vga_red     <= '0;
      o_vga_green   <= '0;
      o_vga_blue    <= '0;
      o_vga_hsync   <= SYNC_OFF;
      o_vga_vsync   <= SYNC_OFF;
      o_visible     <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_vga_red     <= vis ? src_r : '0;
      o_vga_green   <= vis ? src_g : '0;
      o_vga_blue    <= vis ? src_b : '0;
      o_vga_hsync   <= sync_level(ACT_LOW, h_sync);
      o_vga_vsync   <= sync_level(ACT_LOW, v_sync);
      o_visible     <= vis;
      o_frame_start <= at_origin;
    end
  end
endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: full 800-pixel lines with a shortened 10-line frame (8000 cycles).
module tb_vga_timing_generator;
  localparam int HT = 800;
  localparam int VT = 10;
  localparam int FRAME = HT * VT;

  logic clk, rst_n, vga_rst_n;
  logic [10:0] x, y;
  logic [7:0] red, green, blue, o_r, o_g, o_b;
  logic hs, vs, vis, fs;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic tp;
`endif

  int total = 0, passed = 0, fails = 0;

  vga_timing_generator #(
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_vga_reset_n(vga_rst_n),
    .o_vga_x(x), .o_vga_y(y),
    .i_red(red), .i_green(green), .i_blue(blue),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .i_test_pattern(tp),
`endif
    .o_vga_red(o_r), .o_vga_green(o_g), .o_vga_blue(o_b),
    .o_vga_hsync(hs), .o_vga_vsync(vs), .o_visible(vis), .o_frame_start(fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " x"}, 32'(x), 0);
    chk({tag, " y"}, 32'(y), 0);
    chk({tag, " rgb"}, {8'h0, o_r, o_g, o_b}, 0);
    chk({tag, " hsync"}, 32'(hs), 1);
    chk({tag, " vsync"}, 32'(vs), 1);
    chk({tag, " visible"}, 32'(vis), 0);
    chk({tag, " frame_start"}, 32'(fs), 0);
  endtask

  initial begin
    int hs_first, hs_len, vs_first, vs_len, zero_l0, blank_nz, vis_cnt;
    int fs_cnt, fs_first, fs_last;
    bit found;

    rst_n = 1'b0; vga_rst_n = 1'b0;
    red = 8'hFF; green = 8'hA5; blue = 8'h3C;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    tp = 1'b0;
`endif
    repeat (3) step();
    chk_idle("async_reset");

    // Soft reset hold after async release.
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      step();
      chk_idle("soft_hold");
    end

    // Release: (0,0) presented now, first pixel out one cycle later.
    vga_rst_n = 1'b1;
    #1;
    chk("release x", 32'(x), 0);
    chk("release y", 32'(y), 0);
    hs_first = -1; hs_len = 0; vs_first = -1; vs_len = 0;
    zero_l0 = 0; blank_nz = 0; vis_cnt = 0; fs_cnt = 0; fs_first = -1; fs_last = -1;
    for (int c = 1; c <= FRAME + 2; c++) begin
      step();
      chk("x count", 32'(x), 32'(c % HT));
      chk("y count", 32'(y), 32'((c / HT) % VT));
      if (fs) begin fs_cnt++; if (fs_first < 0) fs_first = c; fs_last = c; end
      if (c <= HT) begin
        if (!hs) begin hs_len++; if (hs_first < 0) hs_first = c; end
        if (o_r == 8'h00) zero_l0++;
      end
      if (c <= FRAME) begin
        if (!vs) begin vs_len++; if (vs_first < 0) vs_first = c; end
        if (c > 4 * HT && o_r != 8'h00) blank_nz++;
        if (vis) vis_cnt++;
      end
      if (c == 1) begin
        chk("first pixel rgb", {8'h0, o_r, o_g, o_b}, 32'h00FFA53C);
        chk("first pixel visible", 32'(vis), 1);
      end
      if (c == 640) chk("last visible px", {8'h0, o_r, o_g, o_b}, 32'h00FFA53C);
      if (c == 641) chk("hblank start vis", 32'(vis), 0);
      if (c == 4 * HT + 1) chk("vblank start vis", 32'(vis), 0);
    end
    chk("hsync first", 32'(hs_first), 657);
    chk("hsync len", 32'(hs_len), 96);
    chk("line0 rgb zero", 32'(zero_l0), 160);
    chk("vsync first", 32'(vs_first), 4801);
    chk("vsync len", 32'(vs_len), 1600);
    chk("vblank rgb", 32'(blank_nz), 0);
    chk("visible count", 32'(vis_cnt), 2560);
    chk("fs count", 32'(fs_cnt), 2);
    chk("fs first", 32'(fs_first), 1);
    chk("fs period", 32'(fs_last - fs_first), FRAME);

    // Abandon the raster mid-frame at x=300,y=2.
    found = 1'b0;
    for (int i = 0; i < 3 * HT && !found; i++) begin
      if (x == 11'd300 && y == 11'd2) found = 1'b1;
      else step();
    end
    chk("drop point reached", 32'(found), 1);
    vga_rst_n = 1'b0;
    step();
    chk_idle("mid_drop");
    vga_rst_n = 1'b1;
    fs_cnt = 0; fs_first = -1; fs_last = -1;
    for (int c = 1; c <= FRAME + 1; c++) begin
      step();
      if (fs) begin fs_cnt++; if (fs_first < 0) fs_first = c; fs_last = c; end
    end
    chk("re-release fs count", 32'(fs_cnt), 2);
    chk("re-release fs first", 32'(fs_first), 1);
    chk("re-release fs next", 32'(fs_last), FRAME + 1);

`ifdef VGA_TIMING_TEST_PATTERN_EN
    vga_rst_n = 1'b0;
    step();
    tp = 1'b1; red = 8'h12; green = 8'h34; blue = 8'h56;
    vga_rst_n = 1'b1;
    hs_first = -1; hs_len = 0;
    for (int c = 1; c <= HT; c++) begin
      step();
      if (!hs) begin hs_len++; if (hs_first < 0) hs_first = c; end
      if (c == 1)   chk("bar x0", {8'h0, o_r, o_g, o_b}, 32'h0);
      if (c == 80)  chk("bar x79", {8'h0, o_r, o_g, o_b}, 32'h0);
      if (c == 81)  chk("bar x80", {8'h0, o_r, o_g, o_b}, 32'h00FF0000);
      if (c == 161) chk("bar x160", {8'h0, o_r, o_g, o_b}, 32'h0000FF00);
      if (c == 561) chk("bar x560", {8'h0, o_r, o_g, o_b}, 32'h00FFFFFF);
      if (c == 641) chk("bar hblank", {8'h0, o_r, o_g, o_b}, 32'h0);
    end
    chk("pattern hsync first", 32'(hs_first), 657);
    chk("pattern hsync len", 32'(hs_len), 96);
`endif

    // Asynchronous reset mid-line takes effect without a clock edge.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_mid");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
